// File: rtl/dmem_pkg.sv
// Shared types and widths for the MEM-stage data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Counter preload for a given wait-state count; 0 wait states never loads it.
  function automatic logic [DMEM_CNT_W-1:0] wait_init(input int unsigned w);
    return (w == 0) ? '0 : DMEM_CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
);

  logic              req_valid;
  logic              req_re;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              stall;
  logic              err;

  modport master (
    output req_valid, req_re, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, stall, err
  );

  modport slave (
    input  req_valid, req_re, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, stall, err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, fixed wait states,
// stall back to the pipeline while a request is pending.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam logic [DMEM_CNT_W-1:0] CNT_INIT  = wait_init(WAIT_CYCLES);
  localparam bit                    ZERO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_t              state_q;
  logic [DMEM_CNT_W-1:0]    cnt_q;
  logic                     we_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        wdata_q;
  logic                     resp_valid_q;
  logic                     err_q;
  logic                     rdata_zero_q;

  logic                     is_idle_c;
  logic                     is_resp_c;
  logic                     accept_c;
  logic                     illegal_c;
  logic                     enter_resp_c;
  logic                     op_we_c;
  logic [ADDR_W-1:0]        op_addr_c;
  logic [DATA_W-1:0]        op_wdata_c;
  logic [DATA_W-1:0]        arr_rdata;

  // Request decode; with zero wait states the array is accessed straight from the bus.
  always_comb begin
    is_idle_c    = (state_q == IDLE);
    is_resp_c    = (state_q == RESP);
    accept_c     = 1'b0;
    illegal_c    = 1'b0;
    enter_resp_c = 1'b0;
    op_we_c      = we_q;
    op_addr_c    = addr_q;
    op_wdata_c   = wdata_q;
    if (!rst) begin
      accept_c     = is_idle_c & bus.req_valid & (bus.req_re ^ bus.req_we);
      illegal_c    = is_idle_c & bus.req_valid & bus.req_re & bus.req_we;
      enter_resp_c = (accept_c & ZERO_WAIT) | ((state_q == WAIT) & (cnt_q == '0));
    end
    if (is_idle_c) begin
      op_we_c    = bus.req_we;
      op_addr_c  = bus.req_addr;
      op_wdata_c = bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      resp_valid_q <= enter_resp_c;
      err_q        <= illegal_c;
      if (enter_resp_c) rdata_zero_q <= op_we_c;
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (ZERO_WAIT) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - DMEM_CNT_W'(1);
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (enter_resp_c & op_we_c),
    .re_i    (enter_resp_c & ~op_we_c),
    .addr_i  (op_addr_c),
    .wdata_i (op_wdata_c),
    .rdata_o (arr_rdata)
  );

  // An illegal request in IDLE is dropped by the pipeline, so it must not stall.
  assign bus.req_ready  = ~rst & is_idle_c;
  assign bus.stall      = ~rst & bus.req_valid & (bus.req_re | bus.req_we) & ~is_resp_c
                          & ~(is_idle_c & bus.req_re & bus.req_we);
  assign bus.resp_valid = resp_valid_q;
  assign bus.err        = err_q;
  assign bus.resp_rdata = rdata_zero_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) against a word-array model.
module tb_dmem_responder;

  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_W(32), .ADDR_W(8)) bus0 ();
  dmem_responder_if #(.DATA_W(32), .ADDR_W(8)) bus1 ();

  logic [1:0]  v, re, we;
  logic [7:0]  a  [2];
  logic [31:0] wd [2];

  assign bus0.req_valid = v[0];  assign bus1.req_valid = v[1];
  assign bus0.req_re    = re[0]; assign bus1.req_re    = re[1];
  assign bus0.req_we    = we[0]; assign bus1.req_we    = we[1];
  assign bus0.req_addr  = a[0];  assign bus1.req_addr  = a[1];
  assign bus0.req_wdata = wd[0]; assign bus1.req_wdata = wd[1];

  logic [1:0]  rv_w, rdy_w, st_w, err_w;
  logic [31:0] rd_w [2];
  assign rv_w  = {bus1.resp_valid, bus0.resp_valid};
  assign rdy_w = {bus1.req_ready,  bus0.req_ready};
  assign st_w  = {bus1.stall,      bus0.stall};
  assign err_w = {bus1.err,        bus0.err};
  assign rd_w[0] = bus0.resp_rdata;
  assign rd_w[1] = bus1.resp_rdata;

  dmem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(W0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(W1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  logic [31:0] model    [2][256];
  bit          known    [2][256];
  logic [31:0] last_exp [2];

  task automatic drive(input bit d, input bit vv, input bit r, input bit w,
                       input logic [7:0] ad, input logic [31:0] dat);
    v[d] = vv; re[d] = r; we[d] = w; a[d] = ad; wd[d] = dat;
  endtask

  // Present one legal request and follow it to its response; caller sits mid-cycle.
  task automatic do_req(input bit d, input bit w, input logic [7:0] ad, input logic [31:0] dat,
                        input bit scramble, output int bubbles);
    int          lat, stall_cnt, waitc;
    bit          acc, done;
    logic [31:0] exp;
    waitc = d ? int'(W1) : int'(W0);
    exp   = w ? 32'h0 : model[d][ad];
    drive(d, 1'b1, !w, w, ad, dat);
    #1;
    acc = 0; done = 0; lat = 0; bubbles = 0; stall_cnt = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      checks++;
      if (st_w[d] !== !rv_w[d]) begin
        errors++;
        $display("FAIL stall dut%0d addr=%h cyc=%0d: got %b want %b", d, ad, k, st_w[d], !rv_w[d]);
      end
      if (st_w[d]) stall_cnt++;
      if (acc) begin
        lat++;
        if (rv_w[d]) begin
          done = 1;
          checks++;
          if (lat != waitc + 1) begin
            errors++;
            $display("FAIL latency dut%0d: got %0d want %0d", d, lat, waitc + 1);
          end
          checks++;
          if (rd_w[d] !== exp) begin
            errors++;
            $display("FAIL rdata dut%0d addr=%h we=%b: got %h want %h", d, ad, w, rd_w[d], exp);
          end
          checks++;
          if (stall_cnt != waitc + 1) begin
            errors++;
            $display("FAIL stall_cycles dut%0d: got %0d want %0d", d, stall_cnt, waitc + 1);
          end
        end
      end else if (rdy_w[d]) begin
        acc = 1;
      end else begin
        bubbles++;
      end
      if (acc && lat > 0 && scramble && !done) begin
        a[d]  = 8'($urandom);
        wd[d] = $urandom;
      end
      if (!done) begin
        @(negedge clk); #1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d addr=%h: no resp_valid within 40 cycles", d, ad);
    end
    if (w) begin
      model[d][ad] = dat;
      known[d][ad] = 1'b1;
    end
    last_exp[d] = exp;
  endtask

  // Drop the request and check the idle outputs for n cycles.
  task automatic go_idle(input bit d, input int n);
    drive(d, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rv_w[d] !== 1'b0 || err_w[d] !== 1'b0 || st_w[d] !== 1'b0 || rdy_w[d] !== 1'b1) begin
        errors++;
        $display("FAIL idle dut%0d: rv=%b err=%b stall=%b rdy=%b want 0 0 0 1",
                 d, rv_w[d], err_w[d], st_w[d], rdy_w[d]);
      end
      checks++;
      if (rd_w[d] !== last_exp[d]) begin
        errors++;
        $display("FAIL rdata_hold dut%0d: got %h want %h", d, rd_w[d], last_exp[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rv_w[d] !== 1'b0 || rd_w[d] !== 32'h0 || err_w[d] !== 1'b0 ||
          st_w[d] !== 1'b0 || rdy_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: rv=%b rdata=%h err=%b stall=%b rdy=%b want 0 0 0 0 0",
                 d, rv_w[d], rd_w[d], err_w[d], st_w[d], rdy_w[d]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    rst = 1'b0;
    last_exp[0] = 32'h0;
    last_exp[1] = 32'h0;
    go_idle(1'b0, 1);
    go_idle(1'b1, 1);
  endtask

  task automatic test_store_load();
    int b;
    do_req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, b);
    go_idle(1'b0, 2);
    do_req(1'b0, 1'b0, 8'h10, 32'h0, 1'b1, b);
    go_idle(1'b0, 3);
  endtask

  task automatic test_back_to_back();
    int b;
    for (int d = 0; d < 2; d++) begin
      do_req(1'(d), 1'b1, 8'h03, 32'd5, 1'b0, b);
      do_req(1'(d), 1'b0, 8'h03, 32'h0, 1'b0, b);
      checks++;
      if (b != 1) begin
        errors++;
        $display("FAIL bubble dut%0d: got %0d want 1", d, b);
      end
      go_idle(1'(d), 1);
    end
  endtask

  task automatic test_illegal();
    int b;
    do_req(1'b0, 1'b1, 8'h20, 32'h0000_0055, 1'b0, b);
    go_idle(1'b0, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 32'd7);
    #1;
    checks++;
    if (st_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_stall: stall=%b rdy=%b want 0 1", st_w[0], rdy_w[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (err_w[0] !== 1'b1 || rv_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err: err=%b rv=%b want 1 0", err_w[0], rv_w[0]);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk); #1;
    checks++;
    if (err_w[0] !== 1'b0 || rv_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err_pulse: err=%b rv=%b want 0 0", err_w[0], rv_w[0]);
    end
    do_req(1'b0, 1'b0, 8'h20, 32'h0, 1'b0, b);
    go_idle(1'b0, 1);
  endtask

  task automatic test_reset_mid();
    int b;
    do_req(1'b0, 1'b1, 8'h04, 32'h0000_1234, 1'b0, b);
    go_idle(1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 32'd9);
    @(negedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rv_w[0] !== 1'b0 || rdy_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid dut0 cyc%0d: rv=%b rdy=%b want 0 0", i, rv_w[0], rdy_w[0]);
      end
    end
    rst = 1'b0;
    last_exp[0] = 32'h0;
    last_exp[1] = 32'h0;
    go_idle(1'b0, 2);
    go_idle(1'b1, 1);
    do_req(1'b0, 1'b0, 8'h04, 32'h0, 1'b0, b);
    go_idle(1'b0, 1);
  endtask

  task automatic test_ignored();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (st_w[0] !== 1'b0 || rv_w[0] !== 1'b0 || rdy_w[0] !== 1'b1 || err_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL ignored cyc%0d: stall=%b rv=%b rdy=%b err=%b want 0 0 1 0",
                 i, st_w[0], rv_w[0], rdy_w[0], err_w[0]);
      end
    end
    go_idle(1'b0, 1);
  endtask

  task automatic test_random();
    int          b;
    bit          prev_b2b, w;
    logic [7:0]  ad;
    for (int d = 0; d < 2; d++) begin
      prev_b2b = 0;
      for (int n = 0; n < 40; n++) begin
        ad = 8'(8'h40 + $urandom_range(0, 7));
        w  = !known[d][ad] || ($urandom_range(0, 1) == 1);
        do_req(1'(d), w, ad, $urandom, 1'($urandom_range(0, 1)), b);
        checks++;
        if (b != (prev_b2b ? 1 : 0)) begin
          errors++;
          $display("FAIL random_bubble dut%0d n=%0d: got %0d want %0d", d, n, b, prev_b2b ? 1 : 0);
        end
        prev_b2b = ($urandom_range(0, 1) == 1);
        if (!prev_b2b) go_idle(1'(d), $urandom_range(1, 3));
      end
      go_idle(1'(d), 1);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) begin
        model[d][i] = 32'h0;
        known[d][i] = 1'b0;
      end
    v = '0; re = '0; we = '0;
    a[0] = '0; a[1] = '0; wd[0] = '0; wd[1] = '0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
